// File: rtl/vision_pkg.sv
// Shared constants and helpers for the vision pipeline.
// Pixel width default, 3x3 window size, window index helper.
package vision_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int WIN_N = 9;

  // window element index: row r (0 = oldest), col c (0 = left)
  function automatic int widx(input int r, input int c);
    return 3 * r + c;
  endfunction
endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for sobel_window_gen.
// slave: the window generator; master: the side feeding/draining it.
interface sobel_window_gen_if
  import vision_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0]       s_data;
  logic                    s_valid;
  logic                    s_sof;
  logic                    s_ready;
  logic [WIN_N*DATA_W-1:0] m_window;
  logic                    m_valid;
  logic                    m_sof;
  logic                    m_eol;
  logic                    m_ready;

  modport slave (
    input  s_data, s_valid, s_sof, m_ready,
    output s_ready, m_window, m_valid, m_sof, m_eol
  );

  modport master (
    output s_data, s_valid, s_sof, m_ready,
    input  s_ready, m_window, m_valid, m_sof, m_eol
  );
endinterface

// File: rtl/line_buffer.sv
// One-line pixel store: one write port, one combinational read port.
// Ports: clk, waddr/wdata/we (write), raddr/rdata (read). Not reset.
module line_buffer #(
  parameter  int DEPTH  = 640,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator for the Sobel kernel (interior pixels only).
// Ports: clk, rst (sync, active-high), bus (pixel in, window out stream).
module sobel_window_gen
  import vision_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic               clk,
  input logic               rst,
  sobel_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef logic [WIN_N-1:0][DATA_W-1:0] win_t;

  logic [CW-1:0]     col, c_eff;
  logic [RW-1:0]     row, r_eff;
  logic              acc, emit;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  win_t              win, w_nx, m_win;
  logic              m_valid, m_sof, m_eol;

  assign bus.s_ready  = !m_valid || bus.m_ready;
  assign bus.m_window = m_win;
  assign bus.m_valid  = m_valid;
  assign bus.m_sof    = m_sof;
  assign bus.m_eol    = m_eol;

  assign acc   = bus.s_valid && bus.s_ready;
  // start-of-frame forces the pixel to (0,0)
  assign c_eff = bus.s_sof ? '0 : col;
  assign r_eff = bus.s_sof ? '0 : row;
  assign emit  = (r_eff >= RW'(2)) && (c_eff >= CW'(2));

  // lb0 = line row-1, lb1 = line row-2
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk   (clk),
    .waddr (c_eff),
    .wdata (bus.s_data),
    .we    (acc),
    .raddr (c_eff),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk   (clk),
    .waddr (c_eff),
    .wdata (lb0_rd),
    .we    (acc),
    .raddr (c_eff),
    .rdata (lb1_rd)
  );

  always_comb begin
    w_nx = win;
    for (int r = 0; r < 3; r++) begin
      w_nx[widx(r, 0)] = win[widx(r, 1)];
      w_nx[widx(r, 1)] = win[widx(r, 2)];
    end
    w_nx[widx(0, 2)] = lb1_rd;
    w_nx[widx(1, 2)] = lb0_rd;
    w_nx[widx(2, 2)] = bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      win     <= '0;
      m_win   <= '0;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else begin
      if (acc) begin
        win <= w_nx;
        if (c_eff == CW'(IMG_W - 1)) begin
          col <= '0;
          if (r_eff == RW'(IMG_H - 1)) row <= '0;
          else                         row <= r_eff + 1'b1;
        end else begin
          col <= c_eff + 1'b1;
          row <= r_eff;
        end
      end
      if (acc && emit) begin
        m_win   <= w_nx;
        m_valid <= 1'b1;
        m_sof   <= (r_eff == RW'(2)) && (c_eff == CW'(2));
        m_eol   <= (c_eff == CW'(IMG_W - 1));
      end else if (bus.m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 frame.
// Pixel value = base + row*16 + col; windows checked against a table.
module tb_sobel_window_gen;
  localparam int IW = 5;
  localparam int IH = 4;

  typedef struct {
    logic [7:0] ctr;
    logic       sof;
    logic       eol;
  } exp_t;

  typedef struct {
    logic [71:0] win;
    logic        sof;
    logic        eol;
  } got_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   rdy_low = 0;
  exp_t tbl [6];
  got_t got_q [$];

  sobel_window_gen_if #(.DATA_W(8)) bus ();

  sobel_window_gen #(.DATA_W(8), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready)
      got_q.push_back('{bus.m_window, bus.m_sof, bus.m_eol});
    if (!rst && bus.m_ready && !bus.s_ready) rdy_low++;
  end

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] mk_win(input logic [7:0] base,
                                         input logic [7:0] ctr);
    logic [71:0] w;
    int cr, cc;
    cr = int'(ctr[7:4]);
    cc = int'(ctr[3:0]);
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(3*r+c)*8 +: 8] = base + 8'((cr - 1 + r) * 16 + cc - 1 + c);
    return w;
  endfunction

  task automatic push(input logic [7:0] d, input logic sof);
    int  n;
    logic ok;
    n = 0;
    bus.s_data  = d;
    bus.s_sof   = sof;
    bus.s_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("push_timeout", 72'(n), 72'(0));
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input logic sof,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      push(base + 8'((i / IW) * 16 + i % IW), sof && (i == lo));
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input logic [7:0] base, input string nm);
    got_t g;
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() == 0) begin
        chk({nm, "_missing"}, 72'(i), 72'(6));
      end else begin
        g = got_q.pop_front();
        chk({nm, "_win"}, g.win, mk_win(base, tbl[i].ctr));
        chk({nm, "_sof"}, 72'(g.sof), 72'(tbl[i].sof));
        chk({nm, "_eol"}, 72'(g.eol), 72'(tbl[i].eol));
      end
    end
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_extra"}, 72'(got_q.size()), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] held;
    tbl[0] = '{8'h11, 1'b1, 1'b0};
    tbl[1] = '{8'h12, 1'b0, 1'b0};
    tbl[2] = '{8'h13, 1'b0, 1'b1};
    tbl[3] = '{8'h21, 1'b0, 1'b0};
    tbl[4] = '{8'h22, 1'b0, 1'b0};
    tbl[5] = '{8'h23, 1'b0, 1'b1};

    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", 72'(bus.m_valid), 72'(0));
    chk("rst_m_window", bus.m_window, 72'(0));
    chk("rst_m_sof", 72'(bus.m_sof), 72'(0));
    chk("rst_m_eol", 72'(bus.m_eol), 72'(0));
    chk("rst_s_ready", 72'(bus.s_ready), 72'(1));

    // first window latency and contents
    rdy_low = 0;
    send_frame(8'h00, 1'b1, 0, 11);
    chk("s1_pre_valid", 72'(bus.m_valid), 72'(0));
    send_frame(8'h00, 1'b0, 12, 12);
    chk("s1_valid", 72'(bus.m_valid), 72'(1));
    chk("s1_window", bus.m_window, mk_win(8'h00, 8'h11));
    chk("s1_sof", 72'(bus.m_sof), 72'(1));
    chk("s1_eol", 72'(bus.m_eol), 72'(0));
    send_frame(8'h00, 1'b0, 13, 19);
    idle(3);
    check_frame(8'h00, "s2");
    check_empty("s2");
    chk("s2_ready_low", 72'(rdy_low), 72'(0));

    // backpressure on the first window
    send_frame(8'h00, 1'b1, 0, 12);
    bus.m_ready = 1'b0;
    held = bus.m_window;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s3_s_ready", 72'(bus.s_ready), 72'(0));
      chk("s3_m_valid", 72'(bus.m_valid), 72'(1));
      chk("s3_hold", bus.m_window, held);
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    send_frame(8'h00, 1'b0, 13, 19);
    idle(3);
    check_frame(8'h00, "s3");
    check_empty("s3");

    // back-to-back frames, second without sof
    send_frame(8'h00, 1'b1, 0, 19);
    send_frame(8'h40, 1'b0, 0, 19);
    idle(3);
    check_frame(8'h00, "s4a");
    check_frame(8'h40, "s4b");
    check_empty("s4");

    // resync at pixel (2,1) of an unfinished frame
    send_frame(8'h00, 1'b1, 0, 10);
    send_frame(8'h80, 1'b1, 0, 19);
    idle(3);
    check_frame(8'h80, "s5");
    check_empty("s5");

    // reset while a window is pending
    send_frame(8'h00, 1'b1, 0, 12);
    bus.m_ready = 1'b0;
    chk("s6_pre_valid", 72'(bus.m_valid), 72'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("s6_m_valid", 72'(bus.m_valid), 72'(0));
    chk("s6_s_ready", 72'(bus.s_ready), 72'(1));
    got_q.delete();
    bus.m_ready = 1'b1;
    send_frame(8'h00, 1'b0, 0, 19);
    idle(3);
    check_frame(8'h00, "s6");
    check_empty("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
